// File: rtl/branch_pht_ctrl.sv
// Branch pattern history table controller: 2-bit saturating counters with an init sweep,
// one lookup and one update per cycle, and a one-entry pending write with forwarding.
module branch_pht_ctrl #(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  lookup_en,
  input  logic [INDEX_BITS-1:0] lookup_index,
  output logic                  predict_valid,
  output logic                  predict_taken,
  input  logic                  update_en,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken,
  output logic                  update_ready,
  output logic                  busy
);

  localparam int unsigned Depth = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LastIdx = INDEX_BITS'(Depth - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [INDEX_BITS-1:0] r_init_ptr;
  logic                  r_pend_valid;
  logic [INDEX_BITS-1:0] r_pend_index;
  logic [1:0]            r_pend_value;
  logic                  r_predict_valid;
  logic                  r_predict_taken;
  logic [1:0]            r_table [Depth];

  logic                  w_up_accept;
  logic                  w_lu_accept;
  logic [1:0]            w_up_eff;
  logic [1:0]            w_lu_eff;
  logic [1:0]            w_up_new;
  logic                  w_tbl_we;
  logic [INDEX_BITS-1:0] w_tbl_idx;
  logic [1:0]            w_tbl_val;

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    update_ready = 1'b0;
    unique case (r_state)
      StInit: begin
        busy = 1'b1;
        if (r_init_ptr == LastIdx) w_state_next = StRun;
      end
      StRun: update_ready = 1'b1;
      default: w_state_next = StInit;
    endcase
  end

  assign w_up_accept = update_en && update_ready;
  assign w_lu_accept = lookup_en && (r_state == StRun);

  // The pending entry is not yet in the table, so it overrides the array on a match.
  assign w_up_eff = (r_pend_valid && (r_pend_index == update_index)) ? r_pend_value
                                                                     : r_table[update_index];
  assign w_lu_eff = (r_pend_valid && (r_pend_index == lookup_index)) ? r_pend_value
                                                                     : r_table[lookup_index];

  always_comb begin
    w_up_new = w_up_eff;
    if (update_taken) begin
      if (w_up_eff != 2'b11) w_up_new = w_up_eff + 2'b01;
    end else begin
      if (w_up_eff != 2'b00) w_up_new = w_up_eff - 2'b01;
    end
  end

  always_comb begin
    w_tbl_we  = 1'b0;
    w_tbl_idx = r_pend_index;
    w_tbl_val = r_pend_value;
    if (r_state == StInit) begin
      w_tbl_we  = 1'b1;
      w_tbl_idx = r_init_ptr;
      w_tbl_val = INIT_STATE;
    end else if (r_pend_valid) begin
      w_tbl_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state         <= StInit;
      r_init_ptr      <= '0;
      r_pend_valid    <= 1'b0;
      r_predict_valid <= 1'b0;
      r_predict_taken <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StInit) r_init_ptr <= r_init_ptr + 1'b1;
      r_pend_valid <= w_up_accept;
      if (w_up_accept) begin
        r_pend_index <= update_index;
        r_pend_value <= w_up_new;
      end
      r_predict_valid <= w_lu_accept;
      if (w_lu_accept) r_predict_taken <= w_lu_eff[1];
    end
  end

  // The array is not reset; the init sweep overwrites every entry.
  always_ff @(posedge clock) begin
    if (w_tbl_we) r_table[w_tbl_idx] <= w_tbl_val;
  end

  assign predict_valid = r_predict_valid;
  assign predict_taken = r_predict_taken;

endmodule

// File: tb/tb_branch_pht_ctrl.sv
// Directed bench for branch_pht_ctrl: a per-cycle vector table plus reset/init sequences.
module tb_branch_pht_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       lookup_en;
  logic [5:0] lookup_index;
  logic       predict_valid;
  logic       predict_taken;
  logic       update_en;
  logic [5:0] update_index;
  logic       update_taken;
  logic       update_ready;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       lu_en;
    logic [5:0] lu_idx;
    logic       up_en;
    logic [5:0] up_idx;
    logic       up_tk;
    logic       exp_pv;
    logic       exp_pt;
  } vec_t;

  vec_t vq[$];

  branch_pht_ctrl #(.INDEX_BITS(6), .INIT_STATE(2'b01)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .lookup_en    (lookup_en),
    .lookup_index (lookup_index),
    .predict_valid(predict_valid),
    .predict_taken(predict_taken),
    .update_en    (update_en),
    .update_index (update_index),
    .update_taken (update_taken),
    .update_ready (update_ready),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic le, logic [5:0] li, logic ue, logic [5:0] ui, logic ut,
                              logic pv, logic pt);
    vec_t v;
    v.lu_en = le; v.lu_idx = li; v.up_en = ue; v.up_idx = ui; v.up_tk = ut;
    v.exp_pv = pv; v.exp_pt = pt;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic le, logic [5:0] li, logic ue, logic [5:0] ui, logic ut);
    lookup_en = le; lookup_index = li; update_en = ue; update_index = ui; update_taken = ut;
  endtask

  // One cycle: drive at negedge, sample 1 time unit after the rising edge.
  task automatic cycle(logic le, logic [5:0] li, logic ue, logic [5:0] ui, logic ut);
    @(negedge clock);
    drive(le, li, ue, ui, ut);
    @(posedge clock);
    #1;
  endtask

  // Counts cycles with busy high starting right after reset release; also flags any predict.
  task automatic count_init(output int cnt, output bit pv_seen);
    cnt = 0;
    pv_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (predict_valid) pv_seen = 1'b1;
      if (!busy) break;
      cnt++;
      @(posedge clock);
      #1;
    end
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic do_reset(string tag);
    @(negedge clock);
    reset_n = 1'b0;
    lookup_en = 1'b1;
    update_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check({tag, " reset pv"}, predict_valid, 0);
    check({tag, " reset pt"}, predict_taken, 0);
    check({tag, " reset busy"}, busy, 1);
    check({tag, " reset ready"}, update_ready, 0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int cnt;
    bit pv_seen;
    reset_n = 1'b0;
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);

    // Power-up: init sweep must last exactly 64 cycles.
    do_reset("pwr");
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    count_init(cnt, pv_seen);
    check("pwr busy cycles", cnt, 64);
    check("pwr ready after init", update_ready, 1);
    check("pwr no predict in init", int'(pv_seen), 0);

    //            lu  idx    up  idx   tk   pv  pt
    vq.push_back(mk(1, 6'd0,  0, 6'd0,  0,  1,  0));
    vq.push_back(mk(1, 6'd31, 0, 6'd0,  0,  1,  0));
    vq.push_back(mk(1, 6'd63, 0, 6'd0,  0,  1,  0));
    vq.push_back(mk(0, 6'd0,  0, 6'd0,  0,  0,  0));
    vq.push_back(mk(0, 6'd0,  1, 6'd5,  1,  0,  0)); // 5: 01->10
    vq.push_back(mk(1, 6'd5,  1, 6'd5,  1,  1,  1)); // sees 10 via forward; 10->11
    vq.push_back(mk(1, 6'd5,  1, 6'd5,  1,  1,  1)); // 11->11
    vq.push_back(mk(1, 6'd5,  0, 6'd0,  0,  1,  1));
    vq.push_back(mk(0, 6'd0,  1, 6'd9,  1,  0,  1)); // 9: 01->10, pt holds
    vq.push_back(mk(0, 6'd0,  1, 6'd9,  1,  0,  1)); // 10->11
    vq.push_back(mk(1, 6'd9,  1, 6'd9,  0,  1,  1)); // sees 11; ->10
    vq.push_back(mk(1, 6'd9,  1, 6'd9,  0,  1,  1)); // sees 10; ->01
    vq.push_back(mk(1, 6'd9,  1, 6'd9,  0,  1,  0)); // sees 01; ->00
    vq.push_back(mk(1, 6'd9,  1, 6'd9,  0,  1,  0)); // sees 00; stays 00
    vq.push_back(mk(1, 6'd9,  0, 6'd0,  0,  1,  0));
    vq.push_back(mk(1, 6'd9,  0, 6'd0,  0,  1,  0));
    vq.push_back(mk(1, 6'd12, 1, 6'd12, 1,  1,  0)); // same-cycle: pre-update value 01
    vq.push_back(mk(1, 6'd12, 0, 6'd0,  0,  1,  1));
    vq.push_back(mk(1, 6'd12, 0, 6'd0,  0,  1,  1));
    vq.push_back(mk(0, 6'd0,  0, 6'd0,  0,  0,  1));
    vq.push_back(mk(1, 6'd5,  0, 6'd0,  0,  1,  1));
    vq.push_back(mk(1, 6'd63, 0, 6'd0,  0,  1,  0));

    foreach (vq[i]) begin
      cycle(vq[i].lu_en, vq[i].lu_idx, vq[i].up_en, vq[i].up_idx, vq[i].up_tk);
      check($sformatf("vec%0d pv", i), predict_valid, vq[i].exp_pv);
      check($sformatf("vec%0d pt", i), predict_taken, vq[i].exp_pt);
    end
    check("run busy", busy, 0);
    check("run ready", update_ready, 1);

    // Updates and lookups held high through reset and init must be ignored.
    @(negedge clock);
    drive(1'b1, 6'd3, 1'b1, 6'd3, 1'b1);
    do_reset("init");
    drive(1'b1, 6'd3, 1'b1, 6'd3, 1'b1);
    count_init(cnt, pv_seen);
    check("init busy cycles", cnt, 64);
    check("init no predict", int'(pv_seen), 0);
    cycle(1'b1, 6'd3, 1'b0, 6'd0, 1'b0);
    check("init idx3 pv", predict_valid, 1);
    check("init idx3 pt", predict_taken, 0);
    cycle(1'b1, 6'd3, 1'b0, 6'd0, 1'b0);
    check("init idx3 table pt", predict_taken, 0);

    // Reset right after an accepted update: pending write discarded, sweep restarts.
    cycle(1'b0, 6'd0, 1'b1, 6'd7, 1'b1);
    @(negedge clock);
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    do_reset("mid");
    drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    count_init(cnt, pv_seen);
    check("mid busy cycles", cnt, 64);
    cycle(1'b1, 6'd7, 1'b0, 6'd0, 1'b0);
    check("mid idx7 pv", predict_valid, 1);
    check("mid idx7 pt", predict_taken, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pht_ctrl.md
# branch_pht_ctrl

Controller for the branch pattern history table (PHT). It holds 2^INDEX_BITS two-bit saturating counters and initializes them after reset. It serves one fetch-stage lookup per cycle and sequences resolved-branch updates through a one-entry pending-write stage, forwarding where needed, so that update and lookup never conflict. It sits between fetch (prediction) and execute (branch resolution).

## Interface
- INDEX_BITS, 6, PHT index width; table depth = 2^INDEX_BITS
- INIT_STATE, 2'b01, counter value written to every entry during initialization (weakly not-taken)

- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- lookup_en  in  1  fetch requests a prediction this cycle
- lookup_index  in  INDEX_BITS  PHT entry to read
- predict_valid  out  1  registered; high one cycle after an accepted lookup
- predict_taken  out  1  registered; MSB of looked-up counter
- update_en  in  1  resolved branch presents an update
- update_index  in  INDEX_BITS  PHT entry to update
- update_taken  in  1  actual branch outcome
- update_ready  out  1  high when updates are accepted (state RUN)
- busy  out  1  high during initialization sweep

## Operation
- States: INIT and RUN.
  - While reset_n=0 at a clock edge: state←INIT, init_ptr←0, pending_valid←0, predict_valid←0, predict_taken←0.
  - The table array itself is not reset; it is overwritten by the sweep.
- INIT state:
  - Each cycle: table[init_ptr]←INIT_STATE, then init_ptr←init_ptr+1.
  - When init_ptr = 2^INDEX_BITS−1 is written, the next state is RUN.
  - busy=1, update_ready=0. update_en is ignored (dropped, not queued).
  - lookup_en is ignored; predict_valid stays 0.
- RUN state: busy=0, update_ready=1. No exit except reset.
- Effective read value eff(i):
  - If pending_valid and pending_index=i, eff(i)=pending_value.
  - Otherwise eff(i)=table[i].
- Update (update_en & update_ready in cycle T):
  - Compute new=sat(eff(update_index), update_taken).
  - At edge T: pending_valid←1, pending_index←update_index, pending_value←new.
  - If no update is accepted, pending_valid←0.
  - Every edge with pending_valid=1 writes table[pending_index]←pending_value.
  - Back-to-back updates to the same index chain correctly through forwarding.
- Saturating rule:
  - taken: 00→01→10→11→11.
  - not taken: 11→10→01→00→00.
  - Two-bit arithmetic; never wraps.
- Lookup (lookup_en in RUN, cycle T):
  - At edge T: predict_valid←1, predict_taken←eff(lookup_index)[1].
  - Without lookup_en: predict_valid←0; predict_taken holds its previous value.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update value eff(i), not the new value.

## Timing
- Initialization lasts exactly 2^INDEX_BITS cycles after reset_n returns high. With the default, busy is high for 64 cycles and update_ready rises on cycle 65.
- Lookup latency: 1 cycle (index in cycle T, prediction valid in T+1).
- Update visibility:
  - An update accepted in T affects lookups issued in T+1 or later, via forwarding in T+1 and via the table from T+2.
  - The table entry itself holds the new value after edge T+1.
- Throughput: one lookup and one update per cycle, sustained, with no stalls in RUN.
- Reset asserted mid-sweep or mid-update: any pending write is discarded and the sweep restarts from index 0.

## Test plan
- Reset release, INDEX_BITS=6 -> busy=1 for 64 cycles, update_ready=0. Then busy=0, update_ready=1. Lookups of indices 0, 31 and 63 all return predict_taken=0.
- Index 5, three updates taken=1 on consecutive cycles, lookup of 5 in the following cycle -> counter goes 01→10→11→11, predict_taken=1. Lookup issued the cycle after the first update returns 1.
- Index 9 at 11, four updates taken=0 back-to-back -> 10, 01, 00, 00; lookup afterward gives predict_taken=0, with no wrap to 11.
- Same cycle, lookup 12 and update 12 taken=1 from 01 -> predict_taken=0 in the next cycle. A lookup of 12 one cycle later returns 1.
- update_en and lookup_en asserted during INIT -> no table change, predict_valid=0. After RUN, index 3 still reads 01.
- Reset asserted at update acceptance plus 0 cycles in RUN, index 7 updated to 10 -> after re-init, lookup of 7 returns 01 (predict_taken=0). busy is high for a full 64 cycles.
